quad_encoder_conditioner: RTL and testbench
===========================================

Name: quad_encoder_conditioner

Overview:
Input stage for the encoder speed path. Takes the raw asynchronous quadrature channels (A/B) and synchronises and deglitches them. Decodes direction and a signed position count, flags illegal transitions, and emits a clean 1-cycle strobe per rising edge of channel A. That strobe is the pulse source consumed directly by the downstream RPM frequency counter.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (legal 2..4)
FILTER_CYCLES, 4, consecutive clk samples a new level must hold before it is accepted (legal 1..255)
POS_WIDTH, 32, width of signed position counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enc_a  in  1  raw encoder channel A, asynchronous to clk
enc_b  in  1  raw encoder channel B, asynchronous to clk
err_clr  in  1  clears sticky err
a_filt  out  1  filtered channel A
b_filt  out  1  filtered channel B
pulse  out  1  1-cycle strobe on each rising edge of a_filt; feeds the RPM counter
step  out  1  1-cycle strobe per valid quadrature transition
dir  out  1  last valid direction; 1 = forward
position  out  POS_WIDTH  signed quadrature count (x4 decoding)
err  out  1  sticky illegal-transition flag

Behaviour:
- Reset (rst high at a clk edge):
  - Sync chains, filter counters, a_filt, b_filt, pulse, step, position and err go to 0; dir goes to 1.
  - The FSM enters INIT.
  - Reset asserted mid-operation behaves identically; no partial step or pulse is emitted.
- Synchroniser: SYNC_STAGES-deep chain per channel. Only the last stage feeds the logic.
- Filter, per channel:
  - An 8-bit counter increments each cycle the synchronised level differs from the filtered level.
  - The counter clears to 0 on any cycle where the levels are equal.
  - When the counter would reach FILTER_CYCLES, the filtered level takes the synchronised level and the counter clears.
  - Any run shorter than FILTER_CYCLES is discarded.
- FSM state INIT:
  - Lasts SYNC_STAGES+FILTER_CYCLES cycles after reset release, timed by a dedicated counter.
  - a_filt/b_filt load the synchronised levels directly each cycle (filter bypassed).
  - pulse, step, err and position are frozen.
  - Then the FSM moves to RUN.
- FSM state RUN:
  - prev = {a_filt,b_filt} registered each cycle; cur = new filtered pair.
  - Forward sequence AB: 00→10→11→01→00. Each forward transition: step=1, dir=1, position+1.
  - Reverse sequence is the exact inverse. Each reverse transition: step=1, dir=0, position−1.
  - cur==prev: no action.
  - Both bits change in one cycle: illegal. Set err=1; no step; position and dir unchanged; prev still updates to cur.
- pulse:
  - Asserted for the cycle after a_filt goes 0→1 in RUN, regardless of direction or err.
  - Never asserted in two consecutive cycles.
- Latency: pulse and step assert exactly SYNC_STAGES+FILTER_CYCLES+1 clk edges after the first edge that samples the new stable input level. With defaults this is edge 7.
- position wraps modulo 2^POS_WIDTH (two's complement). No saturation.
- err:
  - Cleared by err_clr in RUN.
  - If err_clr and a new illegal transition occur in the same cycle, the set wins.
- rst has priority over all other inputs.

Test Plan:
- rst with enc_a=enc_b=1 held, run 20 cycles → a_filt=b_filt=1 by the end of INIT; pulse, step and err never assert; position=0.
- Forward: 4 full AB cycles, each level held 10 clk → position=16, 4 pulses, 16 steps, dir=1, err=0; the first pulse lands on edge 7 after enc_a rises.
- Glitch: in RUN, enc_a high for 3 cycles then low → no a_filt change and no pulse. enc_a high for 4+ cycles → a_filt rises and exactly one pulse.
- Reverse from 0: 2 full cycles → position=0xFFFFFFF8 (−8), dir=0, 2 pulses.
- Illegal: AB 00→11 in one step → err=1, position and dir unchanged. err_clr coinciding with a second illegal step → err stays 1. err_clr alone → err=0 next cycle.
- Mid-run reset: at position=5, assert rst for 1 cycle → next cycle position=0, dir=1, err=0; INIT repeats; no pulse or step emitted during INIT.

Source files
------------

// File: rtl/quad_encoder_conditioner_if.sv
// Encoder conditioner bus: raw channels and error clear in, conditioned outputs back.
//   enc_a/enc_b : raw asynchronous quadrature channels
//   err_clr     : clears the sticky illegal-transition flag
//   a_filt/b_filt, pulse, step, dir, position, err : conditioned results
interface quad_encoder_conditioner_if #(
  parameter int unsigned POS_WIDTH = 32
);
  logic                 enc_a;
  logic                 enc_b;
  logic                 err_clr;
  logic                 a_filt;
  logic                 b_filt;
  logic                 pulse;
  logic                 step;
  logic                 dir;
  logic [POS_WIDTH-1:0] position;
  logic                 err;

  modport master (
    output enc_a, enc_b, err_clr,
    input  a_filt, b_filt, pulse, step, dir, position, err
  );

  modport slave (
    input  enc_a, enc_b, err_clr,
    output a_filt, b_filt, pulse, step, dir, position, err
  );
endinterface

// File: rtl/quad_encoder_conditioner.sv
// Quadrature encoder input stage: synchronises and deglitches A/B, decodes
// x4 position and direction, flags illegal transitions and emits a 1-cycle
// pulse per rising edge of filtered A for the RPM counter.
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : slave side of quad_encoder_conditioner_if (inputs enc_a, enc_b,
//         err_clr; outputs a_filt, b_filt, pulse, step, dir, position, err)
module quad_encoder_conditioner #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned POS_WIDTH     = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  quad_encoder_conditioner_if.slave        bus
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned INIT_LEN = SYNC_STAGES + FILTER_CYCLES;
  localparam int unsigned INIT_W   = $clog2(INIT_LEN + 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  // Channel index 1 = A, 0 = B, so a pair reads as {A,B}.
  state_t                          state_q, state_d;
  logic [INIT_W-1:0]               init_cnt_q, init_cnt_d;
  logic [1:0][SYNC_STAGES-1:0]     sync_q, sync_d;
  logic [1:0][CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                      filt_q, filt_d;
  logic [1:0]                      prev_q, prev_d;
  logic                            pulse_q, pulse_d;
  logic                            step_q, step_d;
  logic                            dir_q, dir_d;
  logic                            err_q, err_d;
  logic [POS_WIDTH-1:0]            position_q, position_d;
  logic [1:0]                      raw, sync_last, diff;
  logic                            fwd;

  assign raw = {bus.enc_a, bus.enc_b};

  // INIT timer: lets the sync chains and filters settle before decoding.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      if (init_cnt_q == INIT_W'(INIT_LEN - 1)) begin
        state_d    = ST_RUN;
        init_cnt_d = '0;
      end else begin
        init_cnt_d = init_cnt_q + INIT_W'(1);
      end
    end
  end

  // Synchronisers and run-length deglitch filters.
  always_comb begin
    sync_d    = sync_q;
    cnt_d     = '0;
    filt_d    = filt_q;
    sync_last = '0;
    for (int i = 0; i < 2; i++) begin
      sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      sync_last[i] = sync_q[i][SYNC_STAGES-1];
      if (state_q == ST_INIT) begin
        filt_d[i] = sync_last[i];
      end else if (sync_last[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(FILTER_CYCLES - 1)) begin
          filt_d[i] = sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Quadrature decode; forward successor of {A,B} is {~B, A}.
  always_comb begin
    prev_d     = filt_q;
    pulse_d    = 1'b0;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = err_q;
    position_d = position_q;
    diff       = filt_q ^ prev_q;
    fwd        = (filt_q == {~prev_q[0], prev_q[1]});
    if (state_q == ST_INIT) begin
      // Align prev with the filtered pair so RUN starts without a phantom step.
      prev_d = filt_d;
    end else begin
      pulse_d = ~prev_q[1] & filt_q[1];
      if (diff == 2'b11) begin
        err_d = 1'b1;
      end else begin
        if (bus.err_clr) begin
          err_d = 1'b0;
        end
        if (diff != 2'b00) begin
          step_d     = 1'b1;
          dir_d      = fwd;
          position_d = fwd ? position_q + POS_WIDTH'(1) : position_q - POS_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      sync_q     <= '0;
      cnt_q      <= '0;
      filt_q     <= '0;
      prev_q     <= '0;
      pulse_q    <= 1'b0;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
      position_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      pulse_q    <= pulse_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      position_q <= position_d;
    end
  end

  assign bus.a_filt   = filt_q[1];
  assign bus.b_filt   = filt_q[0];
  assign bus.pulse    = pulse_q;
  assign bus.step     = step_q;
  assign bus.dir      = dir_q;
  assign bus.err      = err_q;
  assign bus.position = position_q;

endmodule

// File: tb/tb_quad_encoder_conditioner.sv
// Bench for quad_encoder_conditioner: directed A/B sequences, an edge-indexed
// behavioural model checked every cycle, plus hand-computed literal checks.
module tb_quad_encoder_conditioner;

  localparam int unsigned S    = 2;
  localparam int unsigned F    = 4;
  localparam int unsigned PW   = 32;
  localparam int          HMAX = 8192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quad_encoder_conditioner_if #(.POS_WIDTH(PW)) bus();

  quad_encoder_conditioner #(
    .SYNC_STAGES  (S),
    .FILTER_CYCLES(F),
    .POS_WIDTH    (PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_pulse = 0;
  int n_step  = 0;

  // Model history, indexed by clock edge number.
  bit raw_a  [HMAX];
  bit raw_b  [HMAX];
  bit sync_a [HMAX];
  bit sync_b [HMAX];
  bit fa_h   [HMAX];
  bit fb_h   [HMAX];
  bit is_run [HMAX];
  int rst_edge  = -1000;
  int init_left = 0;
  bit m_valid   = 1'b0;
  bit m_pulse, m_step, m_dir, m_err;
  logic [PW-1:0] m_pos;

  int e;
  bit sa, sb;
  bit [1:0] cur, prv, dif;
  bit fwd;

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Position of a pair along the forward Gray sequence 00,10,11,01.
  function automatic int gray_idx(input bit [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // A level is accepted once F consecutive RUN samples all disagree with an
  // unchanged filtered level.
  function automatic bit flip_ok(input bit is_a, input int edge_n);
    bit ref_f;
    ref_f = is_a ? fa_h[edge_n-1] : fb_h[edge_n-1];
    for (int j = 0; j < int'(F); j++) begin
      int k;
      k = edge_n - j;
      if (!is_run[k]) return 1'b0;
      if ((is_a ? sync_a[k] : sync_b[k]) == ref_f) return 1'b0;
      if ((is_a ? fa_h[k-1] : fb_h[k-1]) != ref_f) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    e   = cyc;
    if (e >= HMAX) begin
      m_valid = 1'b0;
    end else begin
      raw_a[e] = bus.enc_a;
      raw_b[e] = bus.enc_b;
      if (rst) begin
        rst_edge  = e;
        init_left = int'(S + F);
        sync_a[e] = 1'b0; sync_b[e] = 1'b0;
        fa_h[e]   = 1'b0; fb_h[e]   = 1'b0;
        is_run[e] = 1'b0;
        m_pulse = 1'b0; m_step = 1'b0; m_dir = 1'b1; m_err = 1'b0;
        m_pos   = '0;
        m_valid = 1'b1;
      end else begin
        sa = (e - int'(S) >= rst_edge + 1) ? raw_a[e - int'(S)] : 1'b0;
        sb = (e - int'(S) >= rst_edge + 1) ? raw_b[e - int'(S)] : 1'b0;
        sync_a[e] = sa;
        sync_b[e] = sb;
        m_pulse = 1'b0;
        m_step  = 1'b0;
        if (init_left > 0) begin
          init_left = init_left - 1;
          is_run[e] = 1'b0;
          fa_h[e]   = sa;
          fb_h[e]   = sb;
        end else begin
          is_run[e] = 1'b1;
          fa_h[e] = flip_ok(1'b1, e) ? ~fa_h[e-1] : fa_h[e-1];
          fb_h[e] = flip_ok(1'b0, e) ? ~fb_h[e-1] : fb_h[e-1];
          cur = {fa_h[e-1], fb_h[e-1]};
          prv = is_run[e-1] ? {fa_h[e-2], fb_h[e-2]} : cur;
          dif = cur ^ prv;
          m_pulse = !prv[1] && cur[1];
          if (dif == 2'b11) begin
            m_err = 1'b1;
          end else begin
            if (bus.err_clr) m_err = 1'b0;
            if (dif != 2'b00) begin
              fwd    = (gray_idx(cur) == (gray_idx(prv) + 1) % 4);
              m_step = 1'b1;
              m_dir  = fwd;
              m_pos  = fwd ? m_pos + PW'(1) : m_pos - PW'(1);
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("a_filt",   32'(bus.a_filt), 32'(fa_h[cyc]));
      chk("b_filt",   32'(bus.b_filt), 32'(fb_h[cyc]));
      chk("pulse",    32'(bus.pulse),  32'(m_pulse));
      chk("step",     32'(bus.step),   32'(m_step));
      chk("dir",      32'(bus.dir),    32'(m_dir));
      chk("err",      32'(bus.err),    32'(m_err));
      chk("position", bus.position,    m_pos);
      n_pulse = n_pulse + int'(bus.pulse);
      n_step  = n_step  + int'(bus.step);
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input bit a, input bit b, input int n);
    bus.enc_a = a;
    bus.enc_b = b;
    cyc_n(n);
  endtask

  task automatic do_reset(input bit a, input bit b);
    bus.enc_a = a;
    bus.enc_b = b;
    rst = 1'b1;
    cyc_n(1);
    rst = 1'b0;
  endtask

  int p0, s0;

  initial begin
    rst = 1'b1;
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    bus.err_clr = 1'b0;
    cyc_n(1);
    chk("rst_position", bus.position, 32'h0);
    chk("rst_dir", 32'(bus.dir), 32'h1);
    cyc_n(2);
    rst = 1'b0;
    cyc_n(20);
    chk("init11_a_filt", 32'(bus.a_filt), 32'h1);
    chk("init11_b_filt", 32'(bus.b_filt), 32'h1);
    chk("init11_position", bus.position, 32'h0);
    chk("init11_pulses", 32'(n_pulse), 32'h0);
    chk("init11_steps", 32'(n_step), 32'h0);

    // Forward: four full cycles, 10 clocks per level.
    do_reset(1'b0, 1'b0);
    cyc_n(20);
    p0 = n_pulse; s0 = n_step;
    bus.enc_a = 1'b1;
    cyc_n(6);
    chk("lat_before_edge7", 32'(bus.pulse), 32'h0);
    cyc_n(1);
    chk("lat_edge7_pulse", 32'(bus.pulse), 32'h1);
    chk("lat_edge7_step", 32'(bus.step), 32'h1);
    cyc_n(3);
    set_ab(1'b1, 1'b1, 10);
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b0, 1'b0, 10);
    for (int i = 0; i < 3; i++) begin
      set_ab(1'b1, 1'b0, 10);
      set_ab(1'b1, 1'b1, 10);
      set_ab(1'b0, 1'b1, 10);
      set_ab(1'b0, 1'b0, 10);
    end
    chk("fwd_position", bus.position, 32'd16);
    chk("fwd_pulses", 32'(n_pulse - p0), 32'd4);
    chk("fwd_steps", 32'(n_step - s0), 32'd16);
    chk("fwd_dir", 32'(bus.dir), 32'h1);
    chk("fwd_err", 32'(bus.err), 32'h0);

    // Glitch of 3 samples is rejected; 4 samples is accepted.
    p0 = n_pulse;
    set_ab(1'b1, 1'b0, 3);
    set_ab(1'b0, 1'b0, 15);
    chk("glitch3_pulses", 32'(n_pulse - p0), 32'h0);
    chk("glitch3_position", bus.position, 32'd16);
    set_ab(1'b1, 1'b0, 4);
    bus.enc_a = 1'b0;
    cyc_n(2);
    chk("glitch4_a_filt", 32'(bus.a_filt), 32'h1);
    cyc_n(13);
    chk("glitch4_pulses", 32'(n_pulse - p0), 32'h1);
    chk("glitch4_position", bus.position, 32'd16);

    // Reverse from zero: two full cycles.
    do_reset(1'b0, 1'b0);
    cyc_n(20);
    p0 = n_pulse;
    for (int i = 0; i < 2; i++) begin
      set_ab(1'b0, 1'b1, 10);
      set_ab(1'b1, 1'b1, 10);
      set_ab(1'b1, 1'b0, 10);
      set_ab(1'b0, 1'b0, 10);
    end
    chk("rev_position", bus.position, 32'hFFFF_FFF8);
    chk("rev_dir", 32'(bus.dir), 32'h0);
    chk("rev_pulses", 32'(n_pulse - p0), 32'd2);
    chk("rev_err", 32'(bus.err), 32'h0);

    // Illegal transitions and err_clr priority.
    set_ab(1'b1, 1'b1, 10);
    chk("ill_err", 32'(bus.err), 32'h1);
    chk("ill_position", bus.position, 32'hFFFF_FFF8);
    chk("ill_dir", 32'(bus.dir), 32'h0);
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    cyc_n(6);
    bus.err_clr = 1'b1;
    cyc_n(1);
    bus.err_clr = 1'b0;
    chk("ill_set_beats_clr", 32'(bus.err), 32'h1);
    cyc_n(5);
    bus.err_clr = 1'b1;
    cyc_n(1);
    bus.err_clr = 1'b0;
    chk("err_clr_alone", 32'(bus.err), 32'h0);

    // Mid-run reset at position 5 with dir=0 and err set.
    do_reset(1'b0, 1'b0);
    cyc_n(20);
    set_ab(1'b1, 1'b0, 10);
    set_ab(1'b1, 1'b1, 10);
    set_ab(1'b0, 1'b1, 10);
    set_ab(1'b0, 1'b0, 10);
    set_ab(1'b1, 1'b0, 10);
    set_ab(1'b1, 1'b1, 10);
    set_ab(1'b1, 1'b0, 10);
    set_ab(1'b0, 1'b1, 10);
    chk("pre_rst_position", bus.position, 32'd5);
    chk("pre_rst_dir", 32'(bus.dir), 32'h0);
    chk("pre_rst_err", 32'(bus.err), 32'h1);
    rst = 1'b1;
    cyc_n(1);
    rst = 1'b0;
    chk("midrst_position", bus.position, 32'h0);
    chk("midrst_dir", 32'(bus.dir), 32'h1);
    chk("midrst_err", 32'(bus.err), 32'h0);
    p0 = n_pulse; s0 = n_step;
    cyc_n(6);
    chk("midrst_init_pulses", 32'(n_pulse - p0), 32'h0);
    chk("midrst_init_steps", 32'(n_step - s0), 32'h0);
    cyc_n(10);
    chk("midrst_a_filt", 32'(bus.a_filt), 32'h0);
    chk("midrst_b_filt", 32'(bus.b_filt), 32'h1);
    chk("midrst_position_after", bus.position, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
